// File: rtl/kim_scan_pkg.sv
// Shared constants and types for the KIM-1 display/keypad scan controller.
// The key-result classifier is shared so the frame logic stays compact.
package kim_scan_pkg;

    localparam int NUM_DIG = 6;
    localparam int NUM_ROW = 4;
    localparam int NUM_COL = 7;
    localparam int NUM_KEY = NUM_ROW * NUM_COL;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    typedef struct packed {
        logic       valid;
        logic       multi;
        logic [4:0] code;
    } key_res_t;

    localparam key_res_t KEY_NONE = '0;

    // Bit index in the frame vector equals row*NUM_COL+col, i.e. the key code.
    function automatic key_res_t classify(input logic [NUM_KEY-1:0] bits);
        key_res_t res;
        int       count;
        res   = KEY_NONE;
        count = 0;
        for (int i = 0; i < NUM_KEY; i++) begin
            if (bits[i]) begin
                count++;
                res.code = 5'(i);
            end
        end
        if (count == 1) begin
            res.valid = 1'b1;
        end else if (count > 1) begin
            res.multi = 1'b1;
            res.code  = 5'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/kim_key_debounce.sv
// Frame-rate key debouncer: accepts a result after DEBOUNCE identical frames
// and pulses o_emit when the stable value moves to a new key code.
module kim_key_debounce
    import kim_scan_pkg::*;
#(
    parameter int DEBOUNCE = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frameValid,
    input  key_res_t   i_result,
    output logic       o_emit,
    output logic [4:0] o_emitCode
);

    localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE);

    key_res_t   r_prev;
    key_res_t   r_stable;
    logic [3:0] r_count;
    logic       r_emit;
    logic [4:0] r_emitCode;
    logic [3:0] w_countNext;

    always_comb begin
        w_countNext = 4'd1;
        if (i_result == r_prev) begin
            w_countNext = (r_count == 4'hF) ? 4'hF : r_count + 4'd1;
        end
    end

    // MULTI never becomes stable; release to NONE updates stable silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev     <= KEY_NONE;
            r_stable   <= KEY_NONE;
            r_count    <= '0;
            r_emit     <= 1'b0;
            r_emitCode <= '0;
        end else begin
            r_emit <= 1'b0;
            if (i_frameValid) begin
                r_prev  <= i_result;
                r_count <= w_countNext;
                if (w_countNext == DEB_CNT && !i_result.multi && i_result != r_stable) begin
                    r_stable <= i_result;
                    if (i_result.valid) begin
                        r_emit     <= 1'b1;
                        r_emitCode <= i_result.code;
                    end
                end
            end
        end
    end

    assign o_emit     = r_emit;
    assign o_emitCode = r_emitCode;

endmodule

// File: rtl/kim_scan_ctrl.sv
// KIM-1 scan controller: multiplexes six 7-segment digits, scans four keypad
// rows and hands debounced key codes to the system over valid/ready.
module kim_scan_ctrl
    import kim_scan_pkg::*;
#(
    parameter int TICK_DIV  = 1000,
    parameter int BLANK_CYC = 2,
    parameter int DEBOUNCE  = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       seg_we,
    input  logic [2:0] seg_addr,
    input  logic [6:0] seg_wdata,
    input  logic       disp_en,
    input  logic [6:0] KB_COL,
    output logic [3:0] KB_ROW,
    output logic [5:0] LED_DIG,
    output logic [6:0] LED_SEG,
    output logic       key_valid,
    output logic [4:0] key_code,
    input  logic       key_ready,
    output logic       overrun
);

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
    localparam logic [2:0]  SLOT_LAST  = 3'(NUM_DIG - 1);

    logic [15:0]  r_tick;
    logic [2:0]   r_slot;
    scan_state_t  r_state;
    logic [6:0]   r_ram [NUM_DIG];
    logic [5:0]   r_ledDig;
    logic [6:0]   r_ledSeg;
    logic [3:0]   r_kbRow;
    logic [6:0]   r_colMeta;
    logic [6:0]   r_colSync;
    logic [20:0]  r_rowCols;
    logic         r_keyValid;
    logic [4:0]   r_keyCode;
    logic         r_overrun;

    logic         w_tickLast;
    logic         w_frameValid;
    logic [5:0]   w_digSel;
    logic [3:0]   w_rowSel;
    logic [27:0]  w_frameBits;
    key_res_t     w_frameRes;
    logic         w_emit;
    logic [4:0]   w_emitCode;

    assign w_tickLast   = (r_tick == TICK_LAST);
    assign w_frameValid = w_tickLast && (r_slot == 3'd3);
    assign w_digSel     = 6'b000001 << r_slot;
    assign w_rowSel     = (r_slot < 3'd4) ? (4'b0001 << r_slot[1:0]) : 4'b0000;
    assign w_frameBits  = {~r_colSync, r_rowCols};
    assign w_frameRes   = classify(w_frameBits);

    // Outputs are decoded from the current state, so they lag the counter by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick   <= '0;
            r_slot   <= '0;
            r_state  <= BLANK;
            r_ledDig <= '1;
            r_ledSeg <= '1;
            r_kbRow  <= '1;
        end else begin
            if (w_tickLast) begin
                r_tick  <= '0;
                r_slot  <= (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
                r_state <= BLANK;
            end else begin
                r_tick <= r_tick + 16'd1;
                if (r_tick == BLANK_LAST) begin
                    r_state <= SHOW;
                end
            end
            case (r_state)
                BLANK: begin
                    r_ledDig <= '1;
                    r_ledSeg <= '1;
                    r_kbRow  <= '1;
                end
                SHOW: begin
                    r_ledDig <= disp_en ? ~w_digSel : 6'h3F;
                    r_ledSeg <= disp_en ? ~r_ram[r_slot] : 7'h7F;
                    r_kbRow  <= ~w_rowSel;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                r_ram[i] <= '0;
            end
        end else if (seg_we && seg_addr <= SLOT_LAST) begin
            r_ram[seg_addr] <= seg_wdata;
        end
    end

    // Row 3 is classified straight from the synchronizer on its own sample cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_colMeta <= '1;
            r_colSync <= '1;
            r_rowCols <= '0;
        end else begin
            r_colMeta <= KB_COL;
            r_colSync <= r_colMeta;
            if (w_tickLast) begin
                case (r_slot)
                    3'd0:    r_rowCols[6:0]   <= ~r_colSync;
                    3'd1:    r_rowCols[13:7]  <= ~r_colSync;
                    3'd2:    r_rowCols[20:14] <= ~r_colSync;
                    default: ;
                endcase
            end
        end
    end

    kim_key_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .i_frameValid(w_frameValid),
        .i_result    (w_frameRes),
        .o_emit      (w_emit),
        .o_emitCode  (w_emitCode)
    );

    // An emit coinciding with acceptance reloads; otherwise a pending code wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keyValid <= 1'b0;
            r_keyCode  <= '0;
            r_overrun  <= 1'b0;
        end else if (w_emit) begin
            if (!r_keyValid || key_ready) begin
                r_keyValid <= 1'b1;
                r_keyCode  <= w_emitCode;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_keyValid && key_ready) begin
            r_keyValid <= 1'b0;
        end
    end

    assign KB_ROW    = r_kbRow;
    assign LED_DIG   = r_ledDig;
    assign LED_SEG   = r_ledSeg;
    assign key_valid = r_keyValid;
    assign key_code  = r_keyCode;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_kim_scan_ctrl.sv
// Self-checking bench for kim_scan_ctrl: display table, directed keypad
// sequences, and randomized key patterns against a frame-level model.
module tb_kim_scan_ctrl;

    localparam int TD    = 20;
    localparam int BC    = 2;
    localparam int DB    = 4;
    localparam int FRAME = 6 * TD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       seg_we = 1'b0;
    logic [2:0] seg_addr = '0;
    logic [6:0] seg_wdata = '0;
    logic       disp_en = 1'b1;
    logic [6:0] KB_COL;
    logic [3:0] KB_ROW;
    logic [5:0] LED_DIG;
    logic [6:0] LED_SEG;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready = 1'b1;
    logic       overrun;

    logic [27:0] tbKeys = '0;
    int          edgeCnt = 0;
    int          checks = 0;
    int          fails = 0;
    int          acceptQ[$];
    int          mPrev, mRun, mStable;

    typedef struct {
        logic [2:0] slot;
        int         tick;
        logic       dispEn;
        logic [5:0] expDig;
        logic [6:0] expSeg;
        logic [3:0] expRow;
    } dispVec_t;

    dispVec_t dispTab[10];

    kim_scan_ctrl #(
        .TICK_DIV (TD),
        .BLANK_CYC(BC),
        .DEBOUNCE (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_we   (seg_we),
        .seg_addr (seg_addr),
        .seg_wdata(seg_wdata),
        .disp_en  (disp_en),
        .KB_COL   (KB_COL),
        .KB_ROW   (KB_ROW),
        .LED_DIG  (LED_DIG),
        .LED_SEG  (LED_SEG),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Passive keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        KB_COL = 7'h7F;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (!KB_ROW[r] && tbKeys[r*7+c]) KB_COL[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    always @(negedge clk) begin
        if (!reset && key_valid && key_ready) acceptQ.push_back(int'(key_code));
    end

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge where outputs reflect tick t of slot s.
    task automatic waitPhase(input int s, input int t);
        int target;
        bit found;
        target = s * TD + t;
        found  = 1'b0;
        for (int i = 0; i < FRAME + 2 && !found; i++) begin
            @(negedge clk);
            if (((edgeCnt - 1) % FRAME) == target) found = 1'b1;
        end
        if (!found) begin
            checks++;
            fails++;
            $display("[TB] FAIL phase_wait: got no match, expected slot %0d tick %0d", s, t);
        end
    endtask

    task automatic applyStimulus(input logic [27:0] keys);
        tbKeys = keys;
        waitPhase(4, TD / 2);
    endtask

    task automatic checkEmit(input string name, input int expN, input int expCode);
        int n;
        n = acceptQ.size();
        checkOutput({name, "_count"}, n, expN);
        if (expN == 1 && n == 1) checkOutput({name, "_code"}, acceptQ[0], expCode);
        acceptQ.delete();
    endtask

    task automatic writeSeg(input logic [2:0] addr, input logic [6:0] data);
        @(negedge clk);
        seg_we    = 1'b1;
        seg_addr  = addr;
        seg_wdata = data;
        @(negedge clk);
        seg_we = 1'b0;
    endtask

    function automatic logic [27:0] keyBit(input int k);
        logic [27:0] one;
        one = 28'd1;
        return one << k;
    endfunction

    // Model result encoding: -1 none, -2 several keys, else the key code.
    function automatic int frameResult(input logic [27:0] keys);
        if (keys == '0) return -1;
        if ($countones(keys) > 1) return -2;
        for (int i = 0; i < 28; i++) if (keys[i]) return i;
        return -1;
    endfunction

    task automatic modelFrame(input int res, output int expN, output int expCode);
        expN    = 0;
        expCode = 0;
        mRun    = (res == mPrev) ? mRun + 1 : 1;
        mPrev   = res;
        if (mRun == DB && res != -2 && res != mStable) begin
            mStable = res;
            if (res >= 0) begin
                expN    = 1;
                expCode = res;
            end
        end
    endtask

    initial begin
        int expN, expCode, kind, hold;
        int unsigned a, b;
        logic [27:0] keys;

        dispTab[0] = '{3'd0, TD/2, 1'b1, 6'h3E, 7'h40, 4'hE};
        dispTab[1] = '{3'd1, TD/2, 1'b1, 6'h3D, 7'h79, 4'hD};
        dispTab[2] = '{3'd2, TD/2, 1'b1, 6'h3B, 7'h79, 4'hB};
        dispTab[3] = '{3'd2, 0,    1'b1, 6'h3F, 7'h7F, 4'hF};
        dispTab[4] = '{3'd3, TD/2, 1'b1, 6'h37, 7'h24, 4'h7};
        dispTab[5] = '{3'd4, TD/2, 1'b1, 6'h2F, 7'h30, 4'hF};
        dispTab[6] = '{3'd5, TD-1, 1'b1, 6'h1F, 7'h19, 4'hF};
        dispTab[7] = '{3'd2, TD/2, 1'b0, 6'h3F, 7'h7F, 4'hB};
        dispTab[8] = '{3'd5, BC-1, 1'b1, 6'h3F, 7'h7F, 4'hF};
        dispTab[9] = '{3'd0, BC,   1'b1, 6'h3E, 7'h40, 4'hE};

        repeat (3) @(negedge clk);
        checkOutput("rst_dig", LED_DIG, 6'h3F);
        checkOutput("rst_seg", LED_SEG, 7'h7F);
        checkOutput("rst_row", KB_ROW, 4'hF);
        checkOutput("rst_valid", key_valid, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        reset = 1'b0;

        writeSeg(3'd0, 7'h3F);
        writeSeg(3'd1, 7'h06);
        writeSeg(3'd2, 7'h06);
        writeSeg(3'd3, 7'h5B);
        writeSeg(3'd4, 7'h4F);
        writeSeg(3'd5, 7'h66);
        writeSeg(3'd6, 7'h7F);
        writeSeg(3'd7, 7'h7F);

        foreach (dispTab[i]) begin
            disp_en = dispTab[i].dispEn;
            waitPhase(dispTab[i].slot, dispTab[i].tick);
            checkOutput($sformatf("disp%0d_dig", i), LED_DIG, dispTab[i].expDig);
            checkOutput($sformatf("disp%0d_seg", i), LED_SEG, dispTab[i].expSeg);
            checkOutput($sformatf("disp%0d_row", i), KB_ROW, dispTab[i].expRow);
        end
        disp_en = 1'b1;

        // Write to the digit on show: RAM next cycle, LED_SEG one cycle after.
        waitPhase(3, 8);
        seg_we    = 1'b1;
        seg_addr  = 3'd3;
        seg_wdata = 7'h7F;
        @(negedge clk);
        seg_we = 1'b0;
        checkOutput("midslot_old", LED_SEG, 7'h24);
        @(negedge clk);
        checkOutput("midslot_new", LED_SEG, 7'h00);

        waitPhase(4, TD / 2);
        acceptQ.delete();
        for (int f = 1; f <= DB; f++) begin
            applyStimulus(keyBit(10));
            checkEmit("hold", (f == DB) ? 1 : 0, 10);
        end
        for (int f = 0; f < 20; f++) begin
            applyStimulus(keyBit(10));
            checkEmit("hold_long", 0, 0);
        end
        for (int f = 0; f <= DB; f++) begin
            applyStimulus('0);
            checkEmit("release", 0, 0);
        end
        for (int f = 0; f < 10; f++) begin
            applyStimulus((f % 2 == 0) ? keyBit(10) : 28'd0);
            checkEmit("bounce", 0, 0);
        end
        for (int f = 1; f <= DB; f++) begin
            applyStimulus(keyBit(10));
            checkEmit("steady", (f == DB) ? 1 : 0, 10);
        end
        for (int f = 0; f < 6; f++) begin
            applyStimulus(keyBit(0) | keyBit(1));
            checkEmit("multi", 0, 0);
        end
        for (int f = 0; f < DB + 2; f++) begin
            applyStimulus(keyBit(10));
            checkEmit("multi_keeps_stable", 0, 0);
        end

        key_ready = 1'b0;
        for (int f = 0; f < DB; f++) applyStimulus(keyBit(5));
        checkOutput("ovr_first_valid", key_valid, 1'b1);
        checkOutput("ovr_first_code", key_code, 5'd5);
        checkOutput("ovr_first_flag", overrun, 1'b0);
        for (int f = 0; f < DB; f++) applyStimulus(keyBit(12));
        checkOutput("ovr_valid", key_valid, 1'b1);
        checkOutput("ovr_code", key_code, 5'd5);
        checkOutput("ovr_flag", overrun, 1'b1);
        #1 key_ready = 1'b1;
        @(negedge clk);
        checkOutput("ready_drop", key_valid, 1'b0);
        key_ready = 1'b0;
        checkOutput("ovr_sticky", overrun, 1'b1);
        acceptQ.delete();

        tbKeys = '0;
        waitPhase(1, 7);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_dig", LED_DIG, 6'h3F);
        checkOutput("midrst_seg", LED_SEG, 7'h7F);
        checkOutput("midrst_row", KB_ROW, 4'hF);
        checkOutput("midrst_valid", key_valid, 1'b0);
        checkOutput("midrst_code", key_code, 5'd0);
        checkOutput("midrst_overrun", overrun, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (BC) @(negedge clk);
        checkOutput("post_rst_blank_dig", LED_DIG, 6'h3F);
        @(negedge clk);
        checkOutput("post_rst_show_dig", LED_DIG, 6'h3E);
        checkOutput("post_rst_show_seg", LED_SEG, 7'h7F);
        checkOutput("post_rst_show_row", KB_ROW, 4'hE);

        key_ready = 1'b1;
        acceptQ.delete();
        mPrev   = -1;
        mRun    = 0;
        mStable = -1;
        waitPhase(4, TD / 2);
        modelFrame(-1, expN, expCode);
        checkEmit("rand_first", expN, expCode);
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 9);
            keys = '0;
            if (kind >= 3 && kind <= 7) begin
                keys = keyBit($urandom_range(0, 27));
            end else if (kind >= 8) begin
                a = $urandom_range(0, 27);
                b = (a + $urandom_range(1, 27)) % 28;
                keys = keyBit(a) | keyBit(b);
            end
            hold = $urandom_range(1, 6);
            for (int f = 0; f < hold; f++) begin
                applyStimulus(keys);
                modelFrame(frameResult(keys), expN, expCode);
                checkEmit("rand_emit", expN, expCode);
            end
        end
        checkOutput("rand_overrun", overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
